axi_lite_ram_slave: RTL

//  AXI-lite responder at the slave end of the address-decoding hub: hub slaveN port -> this block's AXI_ift.Slave.

---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_sram.sv | 38 +++
 rtl/axi_lite_ram_slave.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response codes, FSM state types and the response helper
// used by axi_lite_ram_slave (optional decode-error build: AXI_LITE_SLAVE_DECERR_EN).
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic [1:0] range_resp(input logic in_range);
    return in_range ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/axi_lite_sram.sv
// Byte-enabled single-write / single-synchronous-read RAM, read-before-write
// on a shared address. Contents are never reset.
module axi_lite_sram #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(DEPTH)-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [DATA_WIDTH/8-1:0]       i_wbe,
  input  logic                          i_re,
  input  logic [$clog2(DEPTH)-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  localparam int BPW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Both updates are non-blocking, so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
    if (i_we) begin
      for (int b = 0; b < BPW; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI-lite RAM target: independent write and read FSMs over a byte-strobed RAM.
// Define AXI_LITE_SLAVE_DECERR_EN for DECERR on out-of-region accesses (else addresses alias).
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BEGIN      = '0,
  parameter int                        MEM_DEPTH      = 512
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_awaddr,
  input  logic [2:0]                    i_awport,
  input  logic                          i_awvalid,
  output logic                          o_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     i_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                          i_wvalid,
  output logic                          o_wready,
  output logic [1:0]                    o_bresp,
  output logic                          o_bvalid,
  input  logic                          i_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     i_araddr,
  input  logic [2:0]                    i_arport,
  input  logic                          i_arvalid,
  output logic                          o_arready,
  output logic [AXI_DATA_WIDTH-1:0]     o_rdata,
  output logic [1:0]                    o_rresp,
  output logic                          o_rvalid,
  input  logic                          i_rready,
  output wstate_t                       o_wstate,
  output rstate_t                       o_rstate
);

  localparam int BPW  = AXI_DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BPW);
  localparam int IDXW = $clog2(MEM_DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready. Every
  // ready/valid this block drives is a flop, so no input valid reaches an output
  // ready combinationally, and a raised valid holds its payload until ready.

  function automatic logic [IDXW-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - MEM_BEGIN;
    return off[OFFW +: IDXW];
  endfunction

`ifdef AXI_LITE_SLAVE_DECERR_EN
  function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = addr - MEM_BEGIN;
    return (addr >= MEM_BEGIN) && ((off >> OFFW) < AXI_ADDR_WIDTH'(MEM_DEPTH));
  endfunction
`endif

  // ---------------- write channel ----------------
  wstate_t                     r_wstate, w_wstate_nxt;
  logic                        r_aw_got, r_w_got, w_aw_got_nxt, w_w_got_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [BPW-1:0]              r_wstrb;
  logic                        r_awready, r_wready, r_bvalid;
  logic [1:0]                  r_bresp;
  logic                        w_aw_hs, w_w_hs, w_commit, w_aw_in_range;
  logic [AXI_ADDR_WIDTH-1:0]   w_awaddr_eff;
  logic [AXI_DATA_WIDTH-1:0]   w_wdata_eff;
  logic [BPW-1:0]              w_wstrb_eff;

  assign w_aw_hs      = i_awvalid & r_awready;
  assign w_w_hs       = i_wvalid & r_wready;
  // A channel completing this cycle is used directly, so commit needs no extra cycle.
  assign w_awaddr_eff = w_aw_hs ? i_awaddr : r_awaddr;
  assign w_wdata_eff  = w_w_hs ? i_wdata : r_wdata;
  assign w_wstrb_eff  = w_w_hs ? i_wstrb : r_wstrb;

`ifdef AXI_LITE_SLAVE_DECERR_EN
  assign w_aw_in_range = addr_ok(w_awaddr_eff);
`else
  assign w_aw_in_range = 1'b1;
`endif

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_got_nxt = r_aw_got;
    w_w_got_nxt  = r_w_got;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_aw_got_nxt = r_aw_got | w_aw_hs;
        w_w_got_nxt  = r_w_got | w_w_hs;
        if (w_aw_got_nxt && w_w_got_nxt) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
          w_aw_got_nxt = 1'b0;
          w_w_got_nxt  = 1'b0;
        end
      end
      W_RESP: begin
        if (r_bvalid && i_bready) begin
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate  <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_got  <= w_aw_got_nxt;
      r_w_got   <= w_w_got_nxt;
      if (w_aw_hs) begin
        r_awaddr <= i_awaddr;
      end
      if (w_w_hs) begin
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
      r_awready <= (w_wstate_nxt == W_IDLE) && !w_aw_got_nxt;
      r_wready  <= (w_wstate_nxt == W_IDLE) && !w_w_got_nxt;
      r_bvalid  <= (w_wstate_nxt == W_RESP);
      if (w_commit) begin
        r_bresp <= range_resp(w_aw_in_range);
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t                     r_rstate, w_rstate_nxt;
  logic                        r_arready, r_rvalid, r_rd_err;
  logic [1:0]                  r_rresp;
  logic                        w_ar_hs, w_ar_in_range;
  logic [AXI_DATA_WIDTH-1:0]   w_ram_rdata;

  assign w_ar_hs = i_arvalid & r_arready;

`ifdef AXI_LITE_SLAVE_DECERR_EN
  assign w_ar_in_range = addr_ok(i_araddr);
`else
  assign w_ar_in_range = 1'b1;
`endif

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_rvalid && i_rready) begin
          w_rstate_nxt = R_IDLE;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rd_err  <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_DATA);
      if (w_ar_hs) begin
        r_rresp  <= range_resp(w_ar_in_range);
        r_rd_err <= !w_ar_in_range;
      end
    end
  end

  axi_lite_sram #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_commit && w_aw_in_range),
    .i_waddr (word_idx(w_awaddr_eff)),
    .i_wdata (w_wdata_eff),
    .i_wbe   (w_wstrb_eff),
    .i_re    (w_ar_hs),
    .i_raddr (word_idx(i_araddr)),
    .o_rdata (w_ram_rdata)
  );

  // The RAM output register is not reset, so rdata is masked outside R_DATA.
  assign o_rdata   = (r_rvalid && !r_rd_err) ? w_ram_rdata : '0;
  assign o_rresp   = r_rresp;
  assign o_rvalid  = r_rvalid;
  assign o_arready = r_arready;
  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_wstate  = r_wstate;
  assign o_rstate  = r_rstate;

endmodule
